// File: rtl/basic_gate_identifier_pkg.sv
// Shared definitions for the two-input gate identifier: FSM states, gate codes
// and the reference truth tables (bit index {A,B}, so tt[3] is Y(1,1)).
`timescale 1ns/1ps
package basic_gate_identifier_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DECODE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [2:0] GATE_AND     = 3'd0;
    localparam logic [2:0] GATE_OR      = 3'd1;
    localparam logic [2:0] GATE_NOTA    = 3'd2;
    localparam logic [2:0] GATE_NAND    = 3'd3;
    localparam logic [2:0] GATE_NOR     = 3'd4;
    localparam logic [2:0] GATE_XOR     = 3'd5;
    localparam logic [2:0] GATE_XNOR    = 3'd6;
    localparam logic [2:0] GATE_UNKNOWN = 3'd7;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NOTA = 4'b0011;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/basic_gate_identifier_tt_decoder.sv
// Combinational truth-table classifier: 4-bit table in, 3-bit gate code out.
`timescale 1ns/1ps
module basic_gate_identifier_tt_decoder
    import basic_gate_identifier_pkg::*;
(
    input  logic [3:0] i_tt,
    output logic [2:0] o_code
);

    always_comb begin
        case (i_tt)
            TT_AND:  o_code = GATE_AND;
            TT_OR:   o_code = GATE_OR;
            TT_NOTA: o_code = GATE_NOTA;
            TT_NAND: o_code = GATE_NAND;
            TT_NOR:  o_code = GATE_NOR;
            TT_XOR:  o_code = GATE_XOR;
            TT_XNOR: o_code = GATE_XNOR;
            default: o_code = GATE_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/basic_gate_identifier.sv
// Gate identifier: sweeps {A,B} over 00..11 into an external gate, samples Y,
// repeats for PASSES sweeps and classifies the first-pass truth table.
`timescale 1ns/1ps
module basic_gate_identifier
    import basic_gate_identifier_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    output logic       o_probe_a,
    output logic       o_probe_b,
    input  logic       i_probe_y,
    output logic       o_busy,
    output logic       o_done,
    output logic [2:0] o_gate_code,
    output logic [3:0] o_truth_table,
    output logic       o_mismatch
);

    localparam int SW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam int PW = (PASSES <= 1) ? 1 : $clog2(PASSES);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES);
    localparam logic [PW-1:0] PASS_LAST   = PW'(PASSES - 1);

    state_t          r_state;
    state_t          w_next;
    logic [1:0]      r_idx;
    logic [SW-1:0]   r_settle;
    logic [PW-1:0]   r_pass;
    logic [3:0]      r_wtt;
    logic [3:0]      r_ftt;
    logic            r_mis_work;
    logic [1:0]      r_probe;
    logic [3:0]      w_tt_full;
    logic [2:0]      w_code;
    logic            w_last_vec;
    logic            w_last_pass;

    assign w_last_vec  = (r_idx == 2'd3);
    assign w_last_pass = (r_pass == PASS_LAST);

    // Working table with the current sample merged in, for the end-of-pass compare.
    always_comb begin
        w_tt_full        = r_wtt;
        w_tt_full[r_idx] = i_probe_y;
    end

    basic_gate_identifier_tt_decoder u_dec (
        .i_tt   (r_ftt),
        .o_code (w_code)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_next = S_DRIVE;
            S_DRIVE:  w_next = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
            S_SETTLE: if (r_settle == SW'(1)) w_next = S_SAMPLE;
            S_SAMPLE: w_next = (w_last_vec && w_last_pass) ? S_DECODE : S_DRIVE;
            S_DECODE: w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (r_state == S_DRIVE) || (r_state == S_SETTLE) ||
                 (r_state == S_SAMPLE) || (r_state == S_DECODE);
        o_done = (r_state == S_DONE);
    end

    assign o_probe_a = r_probe[1];
    assign o_probe_b = r_probe[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx         <= 2'd0;
            r_settle      <= '0;
            r_pass        <= '0;
            r_wtt         <= 4'd0;
            r_ftt         <= 4'd0;
            r_mis_work    <= 1'b0;
            r_probe       <= 2'd0;
            o_gate_code   <= GATE_UNKNOWN;
            o_truth_table <= 4'd0;
            o_mismatch    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_probe <= 2'd0;
                    if (i_start) begin
                        r_idx      <= 2'd0;
                        r_pass     <= '0;
                        r_mis_work <= 1'b0;
                    end
                end
                S_DRIVE:  r_settle <= SETTLE_LOAD;
                S_SETTLE: r_settle <= r_settle - SW'(1);
                S_SAMPLE: begin
                    r_wtt[r_idx] <= i_probe_y;
                    // Next vector goes onto the probes as DRIVE is entered; 3+1 wraps to 00.
                    r_probe <= (w_last_vec && w_last_pass) ? 2'd0 : 2'(r_idx + 2'd1);
                    r_idx   <= 2'(r_idx + 2'd1);
                    if (w_last_vec) begin
                        if (r_pass == '0)
                            r_ftt <= w_tt_full;
                        else if (w_tt_full != r_ftt)
                            r_mis_work <= 1'b1;
                        if (!w_last_pass)
                            r_pass <= PW'(r_pass + PW'(1));
                    end
                end
                S_DECODE: begin
                    r_probe       <= 2'd0;
                    o_gate_code   <= r_mis_work ? GATE_UNKNOWN : w_code;
                    o_truth_table <= r_ftt;
                    o_mismatch    <= r_mis_work;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_basic_gate_identifier.sv
// Directed bench for basic_gate_identifier: single-pass and two-pass instances
// driven against a behavioural gate model on the probe outputs.
`timescale 1ns/1ps
module tb_basic_gate_identifier;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start1 = 1'b0, start2 = 1'b0;
    logic a1, b1, y1, busy1, done1, mis1;
    logic a2, b2, y2, busy2, done2, mis2;
    logic [2:0] code1, code2;
    logic [3:0] tt1, tt2;
    int mdl1 = 0, mdl2 = 0;
    int n_cmp = 0, n_mis = 0;
    int lat;

    always #5 clk = ~clk;

    // 0 XOR, 1 AND, 2 NOT-A, 3 NOR, 4 stuck-1, 5 OR
    function automatic logic gmodel(input int m, input logic a, input logic b);
        case (m)
            0: return a ^ b;
            1: return a & b;
            2: return ~a;
            3: return ~(a | b);
            4: return 1'b1;
            5: return a | b;
            default: return 1'b0;
        endcase
    endfunction

    assign y1 = gmodel(mdl1, a1, b1);
    assign y2 = gmodel(mdl2, a2, b2);

    basic_gate_identifier #(.SETTLE_CYCLES(2), .PASSES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_start(start1),
        .o_probe_a(a1), .o_probe_b(b1), .i_probe_y(y1),
        .o_busy(busy1), .o_done(done1), .o_gate_code(code1),
        .o_truth_table(tt1), .o_mismatch(mis1)
    );

    basic_gate_identifier #(.SETTLE_CYCLES(2), .PASSES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .i_start(start2),
        .o_probe_a(a2), .o_probe_b(b2), .i_probe_y(y2),
        .o_busy(busy2), .o_done(done2), .o_gate_code(code2),
        .o_truth_table(tt2), .o_mismatch(mis2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start dut d with model m0, switch to m1 at cycle sw_c, pulse start at pulse_c.
    // lat = cycle (1 = cycle after the start edge) in which done is seen, 0 on timeout.
    task automatic run(input int d, input int m0, input int m1, input int sw_c,
                       input int pulse_c, output int lat_o);
        int bad, expi, npass;
        logic [1:0] pr;
        npass = (d == 1) ? 1 : 2;
        if (d == 1) mdl1 = m0; else mdl2 = m0;
        @(negedge clk);
        if (d == 1) start1 = 1'b1; else start2 = 1'b1;
        @(negedge clk);
        lat_o = 0;
        bad = 0;
        for (int c = 1; c <= 200; c++) begin
            start1 = (d == 1) && (c == pulse_c);
            start2 = (d == 2) && (c == pulse_c);
            pr = (d == 1) ? {a1, b1} : {a2, b2};
            expi = (c <= 16 * npass) ? ((c - 1) / 4) % 4 : 0;
            if (pr != 2'(expi)) bad++;
            if (((d == 1) ? busy1 : busy2) !== 1'b1 && c <= 16 * npass + 1) bad++;
            if (c == sw_c) begin
                if (d == 1) mdl1 = m1; else mdl2 = m1;
            end
            if ((d == 1) ? done1 : done2) begin
                lat_o = c;
                break;
            end
            @(negedge clk);
        end
        start1 = 1'b0;
        start2 = 1'b0;
        chk("probe_busy_seq", bad, 0);
    endtask

    int mdl_t[3]          = '{1, 2, 3};
    logic [3:0] tt_t[3]   = '{4'b1000, 4'b0011, 4'b0001};
    logic [2:0] code_t[3] = '{3'd0, 3'd2, 3'd4};

    initial begin
        int ndone;
        repeat (3) @(negedge clk);
        chk("rst_a", a1, 0);
        chk("rst_b", b1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_code", code1, 7);
        chk("rst_tt", tt1, 0);
        chk("rst_mis", mis1, 0);
        chk("rst_code2", code2, 7);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_busy", busy1 | busy2, 0);
        chk("idle_done", done1 | done2, 0);

        run(1, 0, 0, 0, 0, lat);
        chk("xor_lat", lat, 18);
        chk("xor_tt", tt1, 4'b0110);
        chk("xor_code", code1, 5);
        chk("xor_mis", mis1, 0);
        chk("done_busy", busy1, 0);
        @(negedge clk);
        chk("done_pulse", done1, 0);
        chk("hold_code", code1, 5);

        for (int i = 0; i < 3; i++) begin
            run(1, mdl_t[i], mdl_t[i], 0, 0, lat);
            chk("gate_lat", lat, 18);
            chk("gate_tt", tt1, tt_t[i]);
            chk("gate_code", code1, code_t[i]);
            chk("gate_mis", mis1, 0);
        end

        run(1, 4, 4, 0, 0, lat);
        chk("stuck_tt", tt1, 4'b1111);
        chk("stuck_code", code1, 7);
        chk("stuck_mis", mis1, 0);

        run(2, 1, 5, 17, 0, lat);
        chk("p2_lat", lat, 34);
        chk("p2_mis", mis2, 1);
        chk("p2_code", code2, 7);
        chk("p2_tt", tt2, 4'b1000);

        run(2, 0, 0, 0, 0, lat);
        chk("p2ok_lat", lat, 34);
        chk("p2ok_mis", mis2, 0);
        chk("p2ok_code", code2, 5);

        run(1, 1, 1, 0, 5, lat);
        chk("ign_lat", lat, 18);
        chk("ign_code", code1, 0);
        @(negedge clk);
        chk("ign_idle", busy1, 0);

        // Abort in SETTLE of vector 01, where probe_b is high.
        mdl1 = 0;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_b", b1, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_b", b1, 0);
        chk("abort_busy", busy1, 0);
        chk("abort_code", code1, 7);
        chk("abort_tt", tt1, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done1 || busy1) ndone++;
        end
        chk("abort_quiet", ndone, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
